sd_cmd_arbiter: RTL
===================

Name: sd_cmd_arbiter

Overview:
- Shares the single SD command engine (the start/precnt/cmd/arg/clkdiv → busy/done/timeout/syntaxe/resparg interface) between two requesters: port R (sector reader, also performs card init) and port W (sector writer).
- Grants ownership per transaction using a lock/request line. Forwards the owner's command pulses and routes responses back only to the owner.
- Enforces a hold watchdog so a stuck requester cannot starve the other.

Parameters:
- WRITER_PRIORITY, 1: 1 = W wins simultaneous requests; 0 = round-robin (the loser of the last tie wins the next one).
- HOLD_TIMEOUT, 32'd4_000_000: maximum clk cycles one owner may hold the grant.
- IDLE_CLKDIV, 16'd4: value driven on sd_clkdiv while no port owns the engine.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- r_req, w_req  in  1  request/lock; held high for the whole multi-command transaction
- r_start, w_start  in  1  one-cycle command pulse
- r_precnt, w_precnt  in  16  command preamble count
- r_cmd, w_cmd  in  6  command index
- r_arg, w_arg  in  32  command argument
- r_clkdiv, w_clkdiv  in  16  requested SD clock divider
- r_grant, w_grant  out  1  port currently owns the engine
- r_busy, w_busy  out  1  engine busy as seen by the port
- r_done, w_done  out  1  done pulse, routed to owner only
- r_timeout, w_timeout  out  1  response timeout, routed to owner only
- r_syntaxe, w_syntaxe  out  1  response syntax error, routed to owner only
- r_resparg, w_resparg  out  32  response argument, routed to owner only
- sd_start  out  1  registered command pulse to engine
- sd_precnt  out  16  to engine
- sd_cmd  out  6  to engine
- sd_arg  out  32  to engine
- sd_clkdiv  out  16  to engine
- sd_busy, sd_done, sd_timeout, sd_syntaxe  in  1  from engine
- sd_resparg  in  32  from engine
- hold_abort  out  1  one-cycle pulse when the watchdog revokes a grant
- proto_err  out  1  one-cycle pulse when a start arrives from a non-granted port

Behaviour:
- Reset values: all grants 0, sd_start 0, sd_precnt/sd_cmd/sd_arg 0, sd_clkdiv=IDLE_CLKDIV, hold_abort 0, proto_err 0.
  - r_busy=w_busy=1; done/timeout/syntaxe 0 and resparg 0 on both ports.
  - State IDLE, watchdog counter 0, last-served = R.
- Reset asserted mid-command clears everything immediately. Engine state is the engine's own concern.
- FSM states: IDLE, OWN_R, OWN_W, DRAIN.
- IDLE:
  - A single requesting port is granted at the next edge.
  - If both request, the port chosen by WRITER_PRIORITY / round-robin is granted.
  - A port flagged "masked" is ignored.
  - Any port's busy=1 while in IDLE.
- OWN_x:
  - x_grant=1. sd_clkdiv follows x_clkdiv combinationally.
  - The owner's start pulse at cycle t produces sd_start=1 at t+1, with precnt/cmd/arg registered from cycle t. sd_start is one cycle wide.
  - Owner busy = sd_busy | sd_start, so the owner cannot double-fire. The engine raises sd_busy the cycle after sampling sd_start.
  - Owner receives sd_done/sd_timeout/sd_syntaxe/sd_resparg unregistered.
  - Non-owner sees busy=1, all other responses 0.
- Start from a non-granted port is dropped and proto_err pulses for one cycle. A start in IDLE or DRAIN is likewise dropped with proto_err.
- Release:
  - Owner drops x_req → DRAIN if sd_busy|sd_start, else IDLE directly.
  - A start in the same cycle as req drop is dropped and pulses proto_err.
- DRAIN:
  - Grants 0, all ports busy=1.
  - Leave to IDLE on the first cycle with sd_busy=0 and sd_start=0.
  - Minimum one IDLE cycle between owners.
- Watchdog:
  - 32-bit counter, cleared on entering OWN_x, increments each OWN_x cycle.
  - On reaching HOLD_TIMEOUT: hold_abort pulses, owner is marked masked, state goes to DRAIN.
  - A masked port is not granted until its req has been seen low for ≥1 cycle; that clears the mask.
- Round-robin: last-served is updated on every grant. With WRITER_PRIORITY=1 it is ignored.

Decomposition:
- Shared package sd_cmd_pkg holds:
  - state encoding (IDLE, OWN_R, OWN_W, DRAIN);
  - port index constants (PORT_R=0, PORT_W=1);
  - SD command numbers already used in the design (CMD13, CMD17, CMD24).
- One natural sub-module, sd_cmd_hold_watchdog: counter, threshold compare, and abort pulse.

Test Plan:
- Only R requests, starts cmd=13 arg=32'h1234_0000 → r_grant at next edge; sd_start=1 one cycle later with sd_cmd=13, sd_arg=32'h1234_0000; w_busy=1 throughout; r_done mirrors sd_done.
- R and W request in the same cycle with WRITER_PRIORITY=1 → W granted; with WRITER_PRIORITY=0 and two consecutive ties → W then R.
- W owns the engine and drops req while sd_busy=1 → DRAIN with both busy=1; R granted only after sd_busy falls plus one IDLE cycle.
- R pulses start while W owns → sd_start stays 0, proto_err one cycle, r_resparg stays 0.
- HOLD_TIMEOUT=100, W holds req forever → hold_abort at cycle 100 of ownership; W not regranted until w_req low for one cycle; R granted meanwhile.
- rst asserted mid-transaction with sd_start=1 → next sample shows sd_start=0, grants 0, sd_clkdiv=IDLE_CLKDIV.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command-engine arbiter.
//   arb_state_t : arbiter FSM state encoding
//   PORT_R/W    : requester identifiers (also stored as last-served)
//   CMD13/17/24 : SD command indices issued by the reader/writer paths
//   pick_tie    : which port wins when both request in the same cycle
package sd_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_R = 2'd1,
      ST_OWN_W = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_t;

   localparam logic PORT_R = 1'b0;
   localparam logic PORT_W = 1'b1;

   localparam logic [5:0] CMD13 = 6'd13;
   localparam logic [5:0] CMD17 = 6'd17;
   localparam logic [5:0] CMD24 = 6'd24;

   // Round-robin hands the tie to whoever was not served last.
   function automatic logic pick_tie(input logic writer_priority, input logic last_served);
      return writer_priority ? PORT_W : ~last_served;
   endfunction

endpackage

// File: rtl/sd_cmd_hold_watchdog.sv
// Hold watchdog for the arbiter: counts cycles while a port owns the engine.
//   clk, rst   : clock, async active-high reset
//   active     : a port currently owns the engine
//   expire     : combinational, high during the HOLD_TIMEOUT-th owned cycle
//   hold_abort : registered one-cycle pulse following expire
module sd_cmd_hold_watchdog #(
   parameter logic [31:0] HOLD_TIMEOUT = 32'd4_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   output logic expire,
   output logic hold_abort
);

   logic [31:0] hold_cnt;

   // hold_cnt counts completed owned cycles, so the current owned cycle is
   // hold_cnt+1; a zero timeout disables the watchdog.
   assign expire = active && (HOLD_TIMEOUT != 32'd0) &&
                   (hold_cnt == HOLD_TIMEOUT - 32'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt   <= '0;
         hold_abort <= 1'b0;
      end else begin
         hold_abort <= expire;
         if (!active || expire)
            hold_cnt <= '0;
         else
            hold_cnt <= hold_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// Shares one SD command engine between the sector reader (R, also does card
// init) and the sector writer (W). A port locks the engine by holding x_req
// for a whole transaction; only the owner's start pulses are forwarded and
// only the owner sees engine responses.
//   clk, rst                       : clock, async active-high reset
//   r_/w_ req,start,precnt,cmd,arg,clkdiv : requester command side
//   r_/w_ grant,busy,done,timeout,syntaxe,resparg : requester response side
//   sd_start/precnt/cmd/arg/clkdiv : to engine (start, precnt, cmd, arg registered)
//   sd_busy/done/timeout/syntaxe/resparg : from engine
//   hold_abort : pulse when the watchdog revokes a grant
//   proto_err  : pulse when a start is dropped (non-owner, IDLE/DRAIN, req low)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nobody owns the engine, next requester is granted
// ST_OWN_R | reader owns the engine
// ST_OWN_W | writer owns the engine
// ST_DRAIN | grant released while a command is in flight; wait for idle
module sd_cmd_arbiter
   import sd_cmd_pkg::*;
#(
   parameter bit          WRITER_PRIORITY = 1'b1,
   parameter logic [31:0] HOLD_TIMEOUT    = 32'd4_000_000,
   parameter logic [15:0] IDLE_CLKDIV     = 16'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r_req,
   input  logic        w_req,
   input  logic        r_start,
   input  logic        w_start,
   input  logic [15:0] r_precnt,
   input  logic [15:0] w_precnt,
   input  logic [5:0]  r_cmd,
   input  logic [5:0]  w_cmd,
   input  logic [31:0] r_arg,
   input  logic [31:0] w_arg,
   input  logic [15:0] r_clkdiv,
   input  logic [15:0] w_clkdiv,
   output logic        r_grant,
   output logic        w_grant,
   output logic        r_busy,
   output logic        w_busy,
   output logic        r_done,
   output logic        w_done,
   output logic        r_timeout,
   output logic        w_timeout,
   output logic        r_syntaxe,
   output logic        w_syntaxe,
   output logic [31:0] r_resparg,
   output logic [31:0] w_resparg,
   output logic        sd_start,
   output logic [15:0] sd_precnt,
   output logic [5:0]  sd_cmd,
   output logic [31:0] sd_arg,
   output logic [15:0] sd_clkdiv,
   input  logic        sd_busy,
   input  logic        sd_done,
   input  logic        sd_timeout,
   input  logic        sd_syntaxe,
   input  logic [31:0] sd_resparg,
   output logic        hold_abort,
   output logic        proto_err
);

   arb_state_t state;
   logic       r_mask;
   logic       w_mask;
   logic       last_served;

   logic       own_active;
   logic       expire;
   logic       engine_busy;
   logic       r_start_ok;
   logic       w_start_ok;
   logic       fwd_start;
   logic       bad_start;
   logic       r_want;
   logic       w_want;
   logic       grant_w;

   assign own_active  = (state == ST_OWN_R) || (state == ST_OWN_W);
   // sd_start covers the cycle before the engine reflects the command on sd_busy.
   assign engine_busy = sd_busy | sd_start;

   sd_cmd_hold_watchdog #(
      .HOLD_TIMEOUT (HOLD_TIMEOUT)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .active     (own_active),
      .expire     (expire),
      .hold_abort (hold_abort)
   );

   // A start is honoured only from the owner while it still holds req and the
   // grant is not being revoked this cycle.
   assign r_start_ok = (state == ST_OWN_R) && r_req && !expire;
   assign w_start_ok = (state == ST_OWN_W) && w_req && !expire;
   // A repeat start while sd_start is high is swallowed so sd_start stays one cycle wide.
   assign fwd_start  = ((r_start && r_start_ok) || (w_start && w_start_ok)) && !sd_start;
   assign bad_start  = (r_start && !r_start_ok) || (w_start && !w_start_ok);

   assign r_want  = r_req && !r_mask;
   assign w_want  = w_req && !w_mask;
   assign grant_w = w_want && (!r_want || (pick_tie(WRITER_PRIORITY, last_served) == PORT_W));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         r_grant     <= 1'b0;
         w_grant     <= 1'b0;
         sd_start    <= 1'b0;
         sd_precnt   <= '0;
         sd_cmd      <= '0;
         sd_arg      <= '0;
         proto_err   <= 1'b0;
         r_mask      <= 1'b0;
         w_mask      <= 1'b0;
         last_served <= PORT_R;
      end else begin
         sd_start  <= fwd_start;
         proto_err <= bad_start;

         if (fwd_start) begin
            if (state == ST_OWN_W) begin
               sd_precnt <= w_precnt;
               sd_cmd    <= w_cmd;
               sd_arg    <= w_arg;
            end else begin
               sd_precnt <= r_precnt;
               sd_cmd    <= r_cmd;
               sd_arg    <= r_arg;
            end
         end

         // A revoked port stays masked until it has dropped req at least once.
         if (expire && (state == ST_OWN_R))
            r_mask <= 1'b1;
         else if (!r_req)
            r_mask <= 1'b0;

         if (expire && (state == ST_OWN_W))
            w_mask <= 1'b1;
         else if (!w_req)
            w_mask <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (grant_w) begin
                  state       <= ST_OWN_W;
                  w_grant     <= 1'b1;
                  last_served <= PORT_W;
               end else if (r_want) begin
                  state       <= ST_OWN_R;
                  r_grant     <= 1'b1;
                  last_served <= PORT_R;
               end
            end
            ST_OWN_R: begin
               if (expire || !r_req) begin
                  r_grant <= 1'b0;
                  state   <= (expire || engine_busy) ? ST_DRAIN : ST_IDLE;
               end
            end
            ST_OWN_W: begin
               if (expire || !w_req) begin
                  w_grant <= 1'b0;
                  state   <= (expire || engine_busy) ? ST_DRAIN : ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (!engine_busy)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign sd_clkdiv = r_grant ? r_clkdiv : (w_grant ? w_clkdiv : IDLE_CLKDIV);

   assign r_busy    = !r_grant || engine_busy;
   assign w_busy    = !w_grant || engine_busy;

   assign r_done    = r_grant && sd_done;
   assign r_timeout = r_grant && sd_timeout;
   assign r_syntaxe = r_grant && sd_syntaxe;
   assign r_resparg = r_grant ? sd_resparg : '0;

   assign w_done    = w_grant && sd_done;
   assign w_timeout = w_grant && sd_timeout;
   assign w_syntaxe = w_grant && sd_syntaxe;
   assign w_resparg = w_grant ? sd_resparg : '0;

endmodule
